gpu_blitter: RTL and testbench
==============================

# gpu_blitter

Second-generation rectangle engine for the graphics system. It accepts one command at a time over a valid/ready handshake. A command either copies a rectangle from a 16-bit image in memory to the framebuffer, or fills a rectangle with a constant colour. Beyond the first-generation GPU it adds per-axis flip, arbitrary fill rectangles, explicit memory wait handling, skipped fetches for clipped pixels, and a done pulse. It sits between the CPU-side command registers, the memory arbiter and the framebuffer write port.

## Interface
Parameters:
- FB_WIDTH, 400, framebuffer width in pixels
- FB_HEIGHT, 240, framebuffer height in pixels
- ADDR_W, 32, memory byte-address width
- XW, $clog2(FB_WIDTH)+3, width of x/width command fields
- YW, $clog2(FB_HEIGHT)+3, width of y/height command fields

Ports:
- clk  in  1  system clock
- reset  in  1  reset; asynchronous and active-high; one clock
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high exactly when state is IDLE
- cmd_mode  in  1  0 = COPY, 1 = FILL
- cmd_flip_x, cmd_flip_y  in  1 each  mirror the source horizontally/vertically (COPY only)
- cmd_address  in  ADDR_W  image base byte address
- cmd_src_x, cmd_src_y  in  16 each  source offset in pixels
- cmd_image_width  in  16  image stride in pixels
- cmd_width  in  XW  rectangle width
- cmd_height  in  YW  rectangle height
- cmd_x  in  XW  destination left
- cmd_y  in  YW  destination top
- cmd_color  in  16  FILL colour
- mem_addr  out  ADDR_W  byte address of the current fetch
- mem_read  out  1  fetch request
- mem_data  in  16  read data
- mem_valid  in  1  mem_data valid; completes the request
- fb_x  out  $clog2(FB_WIDTH)+1  write x
- fb_y  out  $clog2(FB_HEIGHT)+1  write y
- fb_color  out  16  write colour
- fb_write  out  1  write strobe
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at command completion

## Operation
- Acceptance: a command is accepted on a rising edge with cmd_valid && cmd_ready. All cmd_* fields are latched then. They may change freely afterwards.
- States: IDLE, FETCH, WRITE, FILL, DONE.
- IDLE transitions on accept:
  - width==0 or height==0 → DONE.
  - Otherwise COPY → FETCH, FILL → FILL.
- Scan order: pixel counter (px,py) starts at (0,0). It walks px fastest, wrapping px at width−1 and incrementing py. The last pixel is (width−1, height−1).
- Source coordinates:
  - sx = flip_x ? width−1−px : px
  - sy = flip_y ? height−1−py : py
- Source address: mem_addr = address + 2*((src_y+sy)*image_width + src_x+sx). Arithmetic is modulo 2^ADDR_W.
- Destination: dx = x+px, dy = y+py, computed at XW/YW width. The pixel is visible iff dx<FB_WIDTH and dy<FB_HEIGHT, compared unsigned, so wrapped "negative" positions are clipped. fb_x/fb_y carry the low bits of dx/dy.
- FETCH, pixel visible:
  - mem_read=1 with mem_addr stable until mem_valid is sampled high.
  - At that edge, mem_data is captured and the state moves to WRITE.
- FETCH, pixel clipped: mem_read=0, no fetch. Advance to the next pixel in one cycle, or go to DONE if it was the last pixel.
- WRITE: fb_color = captured data. fb_write = captured bit0 (transparency bit; 0 = skip). Then advance: FETCH, or DONE after the last pixel.
- FILL: each cycle presents one pixel with fb_color=color and fb_write=visible. Bit0 is ignored. Go to DONE after the last pixel.
- DONE: done=1 for one cycle, then IDLE.
- A mem_valid arriving while mem_read=0 is ignored.

## Timing
- Reset (asynchronous) forces:
  - state=IDLE, all latched fields and counters = 0
  - mem_read=0, mem_addr=0, fb_write=0, done=0, busy=0, fb_x=fb_y=0, fb_color=0
  - cmd_ready=1
- Reset mid-command aborts it immediately. No done pulse is produced, and any outstanding fetch is abandoned; the arbiter must drop it on reset.
- Accept edge = cycle 0. Cycle 1: first FETCH with mem_read high, or first FILL write.
- COPY throughput: 2 cycles/visible pixel when mem_valid is high in the first FETCH cycle; each memory wait cycle adds 1. Clipped pixels cost 1 cycle.
- FILL throughput: 1 pixel/cycle. An N-pixel fill is busy for N+1 cycles: N FILL plus DONE.
- A new command can be accepted in the cycle after DONE, when state is IDLE.
- fb_* outputs and mem_read/mem_addr are registered-state functions. They change only on clock edges or on reset.

## Test plan
- COPY 2×2:
  - Stimulus: address=0x1000, src=(1,0), image_width=4, x=y=10; zero-latency memory returning addr[15:0]|1.
  - Reads at 0x1002, 0x1004, 0x100A, 0x100C.
  - Writes at (10,10), (11,10), (10,11), (11,11).
  - done at cycle 9.
- COPY 3×1 with flip_x=1, address=0: read order 4, 2, 0. Returned data with bit0=0 on the second pixel gives no write at x+1.
- Clipping:
  - x=FB_WIDTH−1, width=3 → exactly one mem_read and one write at x=399, done at cycle 5.
  - x=2^XW−1, width=2 → one write at x=0.
- FILL 4×2 at (0,0) with color 0x1234 (bit0=0): 8 consecutive fb_write pulses, busy for 9 cycles.
- width=0: accept → DONE → IDLE with no mem_read and no fb_write; done at cycle 1.
- Stalls and reset:
  - Hold mem_valid low for 5 cycles → mem_addr stable throughout.
  - Assert reset during FETCH → mem_read, busy and fb_write all 0 immediately; cmd_ready=1; the next command executes normally.

Source files
------------

// File: rtl/gpu_blitter.sv
// Rectangle engine: copies a 16-bit image rectangle into the framebuffer (with optional
// per-axis flip) or fills a rectangle with a constant colour, one command at a time.
module gpu_blitter #(
  parameter int FB_WIDTH  = 400,
  parameter int FB_HEIGHT = 240,
  parameter int ADDR_W    = 32,
  parameter int XW        = $clog2(FB_WIDTH) + 3,
  parameter int YW        = $clog2(FB_HEIGHT) + 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_mode,
  input  logic                        cmd_flip_x,
  input  logic                        cmd_flip_y,
  input  logic [ADDR_W-1:0]           cmd_address,
  input  logic [15:0]                 cmd_src_x,
  input  logic [15:0]                 cmd_src_y,
  input  logic [15:0]                 cmd_image_width,
  input  logic [XW-1:0]               cmd_width,
  input  logic [YW-1:0]               cmd_height,
  input  logic [XW-1:0]               cmd_x,
  input  logic [YW-1:0]               cmd_y,
  input  logic [15:0]                 cmd_color,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic                        mem_read,
  input  logic [15:0]                 mem_data,
  input  logic                        mem_valid,
  output logic [$clog2(FB_WIDTH):0]   fb_x,
  output logic [$clog2(FB_HEIGHT):0]  fb_y,
  output logic [15:0]                 fb_color,
  output logic                        fb_write,
  output logic                        busy,
  output logic                        done
);

  localparam int FXW = $clog2(FB_WIDTH) + 1;
  localparam int FYW = $clog2(FB_HEIGHT) + 1;

  typedef enum logic [2:0] {IDLE, FETCH, WRITE, FILL, DONE} state_t;

  state_t              state;
  logic                flip_x, flip_y;
  logic [ADDR_W-1:0]   address;
  logic [15:0]         src_x, src_y, image_width, color, data;
  logic [XW-1:0]       width, x, px;
  logic [YW-1:0]       height, y, py;

  logic [XW-1:0]       sx, dx, next_px;
  logic [YW-1:0]       sy, dy, next_py;
  logic                last_px, last_py, last, visible;
  logic [ADDR_W-1:0]   fetch_addr;

  assign last_px = (px == width - XW'(1));
  assign last_py = (py == height - YW'(1));
  assign last    = last_px && last_py;
  assign next_px = last_px ? '0 : px + XW'(1);
  assign next_py = last_px ? py + YW'(1) : py;

  assign sx = flip_x ? (width - XW'(1) - px) : px;
  assign sy = flip_y ? (height - YW'(1) - py) : py;
  assign dx = x + px;
  assign dy = y + py;
  // Wrapped "negative" destinations land far above the framebuffer and clip here.
  assign visible = (dx < XW'(FB_WIDTH)) && (dy < YW'(FB_HEIGHT));

  assign fetch_addr = address + (((ADDR_W'(src_y) + ADDR_W'(sy)) * ADDR_W'(image_width)
                      + ADDR_W'(src_x) + ADDR_W'(sx)) << 1);

  assign mem_read  = (state == FETCH) && visible;
  assign mem_addr  = mem_read ? fetch_addr : '0;
  assign fb_x      = dx[FXW-1:0];
  assign fb_y      = dy[FYW-1:0];
  assign fb_color  = (state == FILL) ? color : data;
  assign fb_write  = ((state == WRITE) && data[0]) || ((state == FILL) && visible);
  assign busy      = (state != IDLE);
  assign cmd_ready = (state == IDLE);
  assign done      = (state == DONE);

  // Command latch, pixel walk and fetch/write sequencing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      flip_x      <= 1'b0;
      flip_y      <= 1'b0;
      address     <= '0;
      src_x       <= '0;
      src_y       <= '0;
      image_width <= '0;
      color       <= '0;
      data        <= '0;
      width       <= '0;
      height      <= '0;
      x           <= '0;
      y           <= '0;
      px          <= '0;
      py          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            flip_x      <= cmd_flip_x;
            flip_y      <= cmd_flip_y;
            address     <= cmd_address;
            src_x       <= cmd_src_x;
            src_y       <= cmd_src_y;
            image_width <= cmd_image_width;
            color       <= cmd_color;
            width       <= cmd_width;
            height      <= cmd_height;
            x           <= cmd_x;
            y           <= cmd_y;
            px          <= '0;
            py          <= '0;
            if (cmd_width == '0 || cmd_height == '0) state <= DONE;
            else if (cmd_mode)                       state <= FILL;
            else                                     state <= FETCH;
          end
        end
        FETCH: begin
          if (!visible) begin
            if (last) state <= DONE;
            else begin
              px <= next_px;
              py <= next_py;
            end
          end else if (mem_valid) begin
            data  <= mem_data;
            state <= WRITE;
          end
        end
        WRITE: begin
          if (last) state <= DONE;
          else begin
            px    <= next_px;
            py    <= next_py;
            state <= FETCH;
          end
        end
        FILL: begin
          if (last) state <= DONE;
          else begin
            px <= next_px;
            py <= next_py;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gpu_blitter.sv
// Bench for gpu_blitter: directed and random commands checked against a pixel-list model,
// with a memory responder that injects wait states and stray mem_valid pulses.
module tb_gpu_blitter;

  localparam int XW = 12;
  localparam int YW = 11;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic        cmd_mode = 1'b0, cmd_flip_x = 1'b0, cmd_flip_y = 1'b0;
  logic [31:0] cmd_address = '0;
  logic [15:0] cmd_src_x = '0, cmd_src_y = '0, cmd_image_width = '0, cmd_color = '0;
  logic [XW-1:0] cmd_width = '0, cmd_x = '0;
  logic [YW-1:0] cmd_height = '0, cmd_y = '0;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic [15:0] mem_data = '0;
  logic        mem_valid = 1'b0;
  logic [9:0]  fb_x;
  logic [8:0]  fb_y;
  logic [15:0] fb_color;
  logic        fb_write, busy, done;

  gpu_blitter dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mode(cmd_mode), .cmd_flip_x(cmd_flip_x), .cmd_flip_y(cmd_flip_y),
    .cmd_address(cmd_address), .cmd_src_x(cmd_src_x), .cmd_src_y(cmd_src_y),
    .cmd_image_width(cmd_image_width), .cmd_width(cmd_width), .cmd_height(cmd_height),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_color(cmd_color),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_data(mem_data), .mem_valid(mem_valid),
    .fb_x(fb_x), .fb_y(fb_y), .fb_color(fb_color), .fb_write(fb_write),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [63:0] rd_q[$], wr_q[$], exp_rd[$], exp_wr[$];
  int exp_cost, wait_total, stall_err, wait_left;
  int lat_cfg = 0;
  int data_mode = 0;
  logic [31:0] clear_addr = '1;
  logic [15:0] salt = '0;
  bit pending = 0;
  logic [31:0] held_addr = '0;

  bit c_mode, c_fx, c_fy;
  logic [31:0] c_addr;
  int c_sx, c_sy, c_iw, c_w, c_h, c_x, c_y;
  logic [15:0] c_color;

  function automatic logic [15:0] mem_fn(input logic [31:0] a);
    if (data_mode == 0) return (a == clear_addr) ? {a[15:1], 1'b0} : {a[15:1], 1'b1};
    return (a[15:0] * 16'd40503) ^ salt;
  endfunction

  function automatic logic [63:0] pack_wr(input int px, input int py, input logic [15:0] c);
    return {29'd0, px[9:0], py[8:0], c};
  endfunction

  // Memory responder and framebuffer monitor; lat_cfg < 0 picks a random wait per fetch.
  always @(negedge clk) begin
    if (reset) begin
      pending   = 0;
      mem_valid = 1'b0;
    end else begin
      if (fb_write) wr_q.push_back({29'd0, fb_x, fb_y, fb_color});
      if (mem_read) begin
        if (pending && mem_addr !== held_addr) stall_err++;
        if (!pending) wait_left = (lat_cfg < 0) ? int'($urandom_range(0, 3)) : lat_cfg;
        if (wait_left == 0) begin
          mem_valid = 1'b1;
          mem_data  = mem_fn(mem_addr);
          rd_q.push_back({32'd0, mem_addr});
          pending   = 0;
        end else begin
          wait_left--;
          wait_total++;
          mem_valid = 1'b0;
          mem_data  = 16'($urandom);
          pending   = 1;
          held_addr = mem_addr;
        end
      end else begin
        pending   = 0;
        mem_valid = 1'($urandom_range(0, 1));
        mem_data  = 16'($urandom);
      end
    end
  end

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: enumerate the rectangle in scan order and list reads, writes and cycles.
  task automatic build_expected();
    exp_rd.delete();
    exp_wr.delete();
    exp_cost = 1;
    if (c_w != 0 && c_h != 0) begin
      for (int py = 0; py < c_h; py++) begin
        for (int px = 0; px < c_w; px++) begin
          int sx = c_fx ? c_w - 1 - px : px;
          int sy = c_fy ? c_h - 1 - py : py;
          int dx = (c_x + px) % 4096;
          int dy = (c_y + py) % 2048;
          bit vis = (dx < 400) && (dy < 240);
          if (c_mode) begin
            exp_cost++;
            if (vis) exp_wr.push_back(pack_wr(dx, dy, c_color));
          end else if (!vis) begin
            exp_cost++;
          end else begin
            longint a = (longint'(c_addr) +
                         2 * (longint'(c_sy + sy) * c_iw + c_sx + sx)) & 64'hFFFF_FFFF;
            logic [15:0] d = mem_fn(32'(a));
            exp_rd.push_back(64'(a));
            exp_cost += 2;
            if (d[0]) exp_wr.push_back(pack_wr(dx, dy, d));
          end
        end
      end
    end
  endtask

  task automatic apply_stimulus(input bit mode, input bit fx, input bit fy,
                                input logic [31:0] addr, input int sx, input int sy,
                                input int iw, input int w, input int h, input int x,
                                input int y, input logic [15:0] color);
    c_mode = mode; c_fx = fx; c_fy = fy; c_addr = addr;
    c_sx = sx; c_sy = sy; c_iw = iw; c_w = w; c_h = h; c_x = x; c_y = y; c_color = color;
    cmd_mode = mode; cmd_flip_x = fx; cmd_flip_y = fy; cmd_address = addr;
    cmd_src_x = 16'(sx); cmd_src_y = 16'(sy); cmd_image_width = 16'(iw);
    cmd_width = XW'(w); cmd_height = YW'(h); cmd_x = XW'(x); cmd_y = YW'(y);
    cmd_color = color;
    cmd_valid = 1'b1;
    rd_q.delete();
    wr_q.delete();
    wait_total = 0;
    stall_err = 0;
    build_expected();
  endtask

  task automatic scramble_cmd();
    cmd_valid = 1'b0;
    cmd_mode = 1'($urandom); cmd_flip_x = 1'($urandom); cmd_flip_y = 1'($urandom);
    cmd_address = $urandom; cmd_src_x = 16'($urandom); cmd_src_y = 16'($urandom);
    cmd_image_width = 16'($urandom); cmd_width = XW'($urandom); cmd_height = YW'($urandom);
    cmd_x = XW'($urandom); cmd_y = YW'($urandom); cmd_color = 16'($urandom);
  endtask

  task automatic run_and_check(input string tag);
    int cyc = 0;
    int busy_cnt = 0;
    bit got = 0;
    @(posedge clk);
    #1 scramble_cmd();
    while (cyc < 4000 && !got) begin
      @(negedge clk);
      cyc++;
      if (busy) busy_cnt++;
      if (done) got = 1;
    end
    check_output({tag, "_done_seen"}, 64'(got), 64'd1);
    if (got) begin
      check_output({tag, "_done_cycle"}, 64'(cyc), 64'(exp_cost + wait_total));
      check_output({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_cost + wait_total));
    end
    @(negedge clk);
    check_output({tag, "_done_pulse_end"}, 64'(done), 64'd0);
    check_output({tag, "_ready_after"}, 64'(cmd_ready), 64'd1);
    check_output({tag, "_stall_addr"}, 64'(stall_err), 64'd0);
    check_output({tag, "_reads"}, 64'(rd_q.size()), 64'(exp_rd.size()));
    for (int i = 0; i < rd_q.size() && i < exp_rd.size(); i++)
      check_output($sformatf("%s_rd%0d", tag, i), rd_q[i], exp_rd[i]);
    check_output({tag, "_writes"}, 64'(wr_q.size()), 64'(exp_wr.size()));
    for (int i = 0; i < wr_q.size() && i < exp_wr.size(); i++)
      check_output($sformatf("%s_wr%0d", tag, i), wr_q[i], exp_wr[i]);
  endtask

  initial begin
    $display("[TB] start");
    repeat (2) @(negedge clk);
    check_output("rst_ready", 64'(cmd_ready), 64'd1);
    check_output("rst_busy", 64'(busy), 64'd0);
    check_output("rst_done", 64'(done), 64'd0);
    check_output("rst_mem_read", 64'(mem_read), 64'd0);
    check_output("rst_mem_addr", 64'(mem_addr), 64'd0);
    check_output("rst_fb_write", 64'(fb_write), 64'd0);
    check_output("rst_fb_xy_color", {29'd0, fb_x, fb_y, fb_color}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    lat_cfg = 0; data_mode = 0;
    apply_stimulus(0, 0, 0, 32'h1000, 1, 0, 4, 2, 2, 10, 10, 16'h0);
    run_and_check("copy2x2");

    clear_addr = 32'd2;
    apply_stimulus(0, 1, 0, 32'h0, 0, 0, 8, 3, 1, 20, 20, 16'h0);
    run_and_check("flipx");
    clear_addr = '1;

    apply_stimulus(0, 0, 0, 32'h200, 0, 0, 16, 3, 1, 399, 0, 16'h0);
    run_and_check("clip_right");

    apply_stimulus(0, 0, 1, 32'h300, 2, 3, 16, 2, 1, 4095, 5, 16'h0);
    run_and_check("clip_wrap");

    apply_stimulus(1, 0, 0, 32'h0, 0, 0, 0, 4, 2, 0, 0, 16'h1234);
    run_and_check("fill4x2");

    apply_stimulus(0, 0, 0, 32'h400, 0, 0, 4, 0, 3, 0, 0, 16'h0);
    run_and_check("width0");

    lat_cfg = 5;
    apply_stimulus(0, 1, 1, 32'h8000, 3, 2, 32, 2, 2, 100, 50, 16'h0);
    run_and_check("stall5");

    // Abort a command while a fetch is stalled; reset must clear outputs immediately.
    lat_cfg = 20;
    apply_stimulus(0, 0, 0, 32'h1000, 1, 0, 4, 2, 2, 10, 10, 16'h0);
    @(posedge clk);
    #1 scramble_cmd();
    repeat (3) @(negedge clk);
    check_output("abort_pre_read", 64'(mem_read), 64'd1);
    #1 reset = 1'b1;
    #1;
    check_output("abort_mem_read", 64'(mem_read), 64'd0);
    check_output("abort_busy", 64'(busy), 64'd0);
    check_output("abort_fb_write", 64'(fb_write), 64'd0);
    check_output("abort_ready", 64'(cmd_ready), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output($sformatf("abort_no_done%0d", i), 64'(done), 64'd0);
    end
    lat_cfg = 0;
    apply_stimulus(0, 0, 0, 32'h1000, 1, 0, 4, 2, 2, 10, 10, 16'h0);
    run_and_check("after_abort");

    lat_cfg = -1; data_mode = 1;
    for (int n = 0; n < 10; n++) begin
      int xs = int'($urandom_range(0, 2));
      int ys = int'($urandom_range(0, 2));
      int rx = (xs == 0) ? int'($urandom_range(0, 399)) :
               (xs == 1) ? int'($urandom_range(390, 399)) : int'($urandom_range(4090, 4095));
      int ry = (ys == 0) ? int'($urandom_range(0, 239)) :
               (ys == 1) ? int'($urandom_range(232, 239)) : int'($urandom_range(2040, 2047));
      salt = 16'($urandom);
      apply_stimulus(1'($urandom), 1'($urandom), 1'($urandom), $urandom,
                     int'($urandom_range(0, 300)), int'($urandom_range(0, 300)),
                     int'($urandom_range(1, 640)), int'($urandom_range(0, 6)),
                     int'($urandom_range(0, 4)), rx, ry, 16'($urandom));
      run_and_check($sformatf("rand%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
